// File: rtl/seg7_pkg.sv
// Shared definitions for the HEX display writer: segment table, blank pattern and FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry k is the active-high a..g pattern for hex digit k (bit0 = a).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high 7-segment decoder.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_writer.sv
// Decodes a multi-digit hex value and writes one segment pattern per cycle to the
// display registers, most significant digit first, with optional leading-zero blanking.
module seg7_writer
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Blank,
    input  logic                    Start,
    output logic [6:0]              Data,
    output logic [ADDR_W-1:0]       Addr,
    output logic                    Sel,
    output logic                    Busy,
    output logic                    Done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic                    blank_q, blank_d;
    logic                    seen_q, seen_d;
    logic [6:0]              data_q, data_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    sel_q, sel_d, busy_q, busy_d, done_q, done_d;

    // On the accepting edge the first digit comes straight from the inputs so that
    // the first write appears right after that edge; afterwards the latched copies rule.
    logic                    accept;
    logic [4*NUM_DIGITS-1:0] src_value;
    logic                    src_blank, src_seen;
    logic [ADDR_W-1:0]       nxt_idx;
    logic [3:0]              nibble;
    logic [6:0]              seg;

    assign accept    = Start && (state_q != WRITE);
    assign src_value = accept ? Value : value_q;
    assign src_blank = accept ? Blank : blank_q;
    assign src_seen  = accept ? 1'b0 : seen_q;
    assign nxt_idx   = accept ? LastIdx : idx_q - ADDR_W'(1);
    assign nibble    = 4'(src_value >> {nxt_idx, 2'b00});

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (seg)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        value_d = value_q;
        blank_d = blank_q;
        seen_d  = seen_q;
        data_d  = data_q;
        addr_d  = addr_q;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (accept) begin
            value_d = Value;
            blank_d = Blank;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (idx_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == WRITE) begin
            idx_d  = nxt_idx;
            addr_d = nxt_idx;
            sel_d  = 1'b1;
            busy_d = 1'b1;
            seen_d = src_seen | (nibble != 4'h0);
            // Digit 0 always shows, so an all-zero value still displays "0".
            if (src_blank && !src_seen && nibble == 4'h0 && nxt_idx != '0) begin
                data_d = SEG_OFF;
            end else begin
                data_d = seg;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            value_q <= '0;
            blank_q <= 1'b0;
            seen_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            blank_q <= blank_d;
            seen_q  <= seen_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Data = data_q;
    assign Addr = addr_q;
    assign Sel  = sel_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_seg7_writer.sv
// Directed bench for seg7_writer with a behavioural six-register display stage downstream.
module tb_seg7_writer;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [23:0] Value;
    logic        Blank;
    logic        Start;
    logic [6:0]  Data;
    logic [2:0]  Addr;
    logic        Sel, Busy, Done;

    int checks   = 0;
    int failures = 0;

    logic [6:0] disp [6];

    seg7_writer #(.NUM_DIGITS(6), .ADDR_W(3)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Value  (Value),
        .Blank  (Blank),
        .Start  (Start),
        .Data   (Data),
        .Addr   (Addr),
        .Sel    (Sel),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    // Downstream display registers H0..H5.
    always @(posedge Clock) begin
        if (Sel && Addr < 3'd6) disp[Addr] <= Data;
    end

    // Stimulus only: request an update, sampled on the next posedge.
    task automatic pulse_start(input logic [23:0] v, input logic b);
        Value = v; Blank = b; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Start = 1'b1; Value = 24'h123456; Blank = 1'b0;
        repeat (2) @(negedge Clock);
        checks++;
        if (Sel !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Data !== 7'h00 || Addr !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs got sel=%b busy=%b done=%b data=%h addr=%0d want all zero",
                     Sel, Busy, Done, Data, Addr);
        end
        Start = 1'b0; Resetn = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_basic();
        logic [6:0] exp [6];
        logic [6:0] hexp [6];
        exp  = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        hexp = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        pulse_start(24'h123456, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (Sel !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0 || Addr !== 3'(5 - i) || Data !== exp[i]) begin
                failures++;
                $display("FAIL basic_write%0d got sel=%b busy=%b done=%b addr=%0d data=%h want 1 1 0 %0d %h",
                         i, Sel, Busy, Done, Addr, Data, 5 - i, exp[i]);
            end
            @(negedge Clock);
        end
        checks++;
        if (Done !== 1'b1 || Sel !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got done=%b sel=%b busy=%b want 1 0 0", Done, Sel, Busy);
        end
        @(negedge Clock);
        checks++;
        if (Done !== 1'b0 || Sel !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got done=%b sel=%b want 0 0", Done, Sel);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (disp[k] !== hexp[k]) begin
                failures++;
                $display("FAIL basic_H%0d got %h want %h", k, disp[k], hexp[k]);
            end
        end
    endtask

    task automatic test_blank_a();
        pulse_start(24'h00000A, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (Sel !== 1'b1 || Addr !== 3'(5 - i) || Data !== ((i == 5) ? 7'h77 : 7'h00)) begin
                failures++;
                $display("FAIL blank_a_write%0d got sel=%b addr=%0d data=%h want 1 %0d %h",
                         i, Sel, Addr, Data, 5 - i, (i == 5) ? 7'h77 : 7'h00);
            end
            @(negedge Clock);
        end
        checks++;
        if (Done !== 1'b1) begin
            failures++;
            $display("FAIL blank_a_done got %b want 1", Done);
        end
        @(negedge Clock);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (disp[k] !== ((k == 0) ? 7'h77 : 7'h00)) begin
                failures++;
                $display("FAIL blank_a_H%0d got %h want %h", k, disp[k], (k == 0) ? 7'h77 : 7'h00);
            end
        end
    endtask

    task automatic test_zero();
        for (int b = 1; b >= 0; b--) begin
            pulse_start(24'h000000, 1'(b));
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (Sel !== 1'b1 || Addr !== 3'(5 - i) ||
                    Data !== ((b == 1 && i < 5) ? 7'h00 : 7'h3F)) begin
                    failures++;
                    $display("FAIL zero_blank%0d_write%0d got sel=%b addr=%0d data=%h want 1 %0d %h",
                             b, i, Sel, Addr, Data, 5 - i, (b == 1 && i < 5) ? 7'h00 : 7'h3F);
                end
                @(negedge Clock);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_ignore_restart();
        logic [6:0] exp [6];
        int dones;
        exp   = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        dones = 0;
        pulse_start(24'hABCDEF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (Sel !== 1'b1 || Addr !== 3'(5 - i) || Data !== exp[i]) begin
                failures++;
                $display("FAIL restart_write%0d got sel=%b addr=%0d data=%h want 1 %0d %h",
                         i, Sel, Addr, Data, 5 - i, exp[i]);
            end
            if (Done === 1'b1) dones++;
            if (i == 2) begin Value = 24'h111111; Start = 1'b1; end
            else Start = 1'b0;
            @(negedge Clock);
        end
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (Done === 1'b1) dones++;
            if (i > 0 && Sel !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL restart_extra_write got sel=%b want 0", Sel);
            end
            @(negedge Clock);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL restart_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_abort();
        logic [6:0] exp [6];
        exp = '{7'h3F, 7'h71, 7'h3F, 7'h79, 7'h3F, 7'h5E};
        pulse_start(24'h123456, 1'b0);
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        checks++;
        if (Sel !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs got sel=%b busy=%b done=%b want 0 0 0", Sel, Busy, Done);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            checks++;
            if (Sel !== 1'b0 || Done !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet%0d got sel=%b done=%b want 0 0", i, Sel, Done);
            end
        end
        pulse_start(24'h0F0E0D, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (Sel !== 1'b1 || Addr !== 3'(5 - i) || Data !== exp[i]) begin
                failures++;
                $display("FAIL abort_rerun_write%0d got sel=%b addr=%0d data=%h want 1 %0d %h",
                         i, Sel, Addr, Data, 5 - i, exp[i]);
            end
            @(negedge Clock);
        end
        checks++;
        if (Done !== 1'b1) begin
            failures++;
            $display("FAIL abort_rerun_done got %b want 1", Done);
        end
        @(negedge Clock);
    endtask

    task automatic test_back_to_back();
        Value = 24'h000001; Blank = 1'b1; Start = 1'b1;
        @(negedge Clock);
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (i < 6) begin
                    if (Sel !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0 || Addr !== 3'(5 - i) ||
                        Data !== ((i == 5) ? 7'h06 : 7'h00)) begin
                        failures++;
                        $display("FAIL b2b_seq%0d_write%0d got sel=%b busy=%b done=%b addr=%0d data=%h",
                                 s, i, Sel, Busy, Done, Addr, Data);
                    end
                end else begin
                    if (Done !== 1'b1 || Sel !== 1'b0 || Busy !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_seq%0d_done got done=%b sel=%b busy=%b want 1 0 0",
                                 s, Done, Sel, Busy);
                    end
                    if (s == 2) Start = 1'b0;
                end
                @(negedge Clock);
            end
        end
        checks++;
        if (Sel !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop got sel=%b done=%b busy=%b want 0 0 0", Sel, Done, Busy);
        end
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; Value = '0; Blank = 1'b0;
        @(negedge Clock);
        test_reset();
        test_basic();
        test_blank_a();
        test_zero();
        test_ignore_restart();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
